// File: rtl/stim_pkg.sv
// Shared types and defaults for the stimulus stream player.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_PASS_W = 16;

    // A requested length longer than the memory plays the whole memory once per pass.
    function automatic int clamp_count(input int count, input int depth);
        return (count > depth) ? depth : count;
    endfunction

endpackage

// File: rtl/stim_mem.sv
// Stimulus vector store: one synchronous write port, one combinational read port.
module stim_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; they are preloaded before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_stream_player.sv
// Streams preloaded stimulus words 0..count-1 over valid/ready, one-shot or looping.
//
// Handshake: a word moves when out_valid && out_ready are both high on a rising
// edge. Once out_valid is raised, out_data/out_last/word_idx stay stable until
// that transfer happens; only stop or reset can withdraw a presented word.
module stim_stream_player
    import stim_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   count,
    input  logic              mode_loop,
    input  logic              start,
    input  logic              stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W-1:0] word_idx,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              loop_q, loop_d;
    logic              valid_d, last_d;
    logic [ADDR_W-1:0] idx_d;
    logic [DATA_W-1:0] data_d;
    logic [PASS_W-1:0] pass_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   cnt_in;
    logic [ADDR_W:0]   next_pos;
    logic              xfer;
    logic              start_ok;

    assign xfer     = out_valid && out_ready;
    assign start_ok = start && (count != '0);
    assign cnt_in   = (ADDR_W+1)'(clamp_count(int'(count), DEPTH));
    assign next_pos = {1'b0, word_idx} + ONE;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

    // Writes are only accepted while not streaming, so a pass never sees a torn vector.
    stim_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (load_en && (state_q != RUN)),
        .wr_addr(load_addr),
        .wr_data(load_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    // Read address of the word to present next: the following index mid-pass, else word 0.
    always_comb begin
        rd_addr = '0;
        if (state_q == RUN && xfer && !out_last) begin
            rd_addr = next_pos[ADDR_W-1:0];
        end
    end

    // Next-state and next-output logic; stop outranks every other request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        valid_d = out_valid;
        last_d  = out_last;
        idx_d   = word_idx;
        data_d  = out_data;
        pass_d  = pass_cnt;
        if (stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_d = RUN;
                        cnt_d   = cnt_in;
                        loop_d  = mode_loop;
                        pass_d  = '0;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        data_d  = rd_data;
                        last_d  = (cnt_in == ONE);
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (out_last) begin
                            pass_d = (&pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
                            if (loop_q) begin
                                idx_d  = '0;
                                data_d = rd_data;
                                last_d = (cnt_q == ONE);
                            end else begin
                                state_d = DONE;
                                valid_d = 1'b0;
                                last_d  = 1'b0;
                            end
                        end else begin
                            idx_d  = next_pos[ADDR_W-1:0];
                            data_d = rd_data;
                            last_d = (next_pos == cnt_q - ONE);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, latched play parameters and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            loop_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            word_idx  <= '0;
            out_data  <= '0;
            pass_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loop_q    <= loop_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            word_idx  <= idx_d;
            out_data  <= data_d;
            pass_cnt  <= pass_d;
        end
    end

endmodule

// File: tb/tb_stim_stream_player.sv
// Self-checking bench for stim_stream_player.
module tb_stim_stream_player;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PASS_W = 16;
    localparam int EXP_W  = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              rst_n;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W:0]   count;
    logic              mode_loop;
    logic              start;
    logic              stop;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [ADDR_W-1:0] word_idx;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pass_cnt;

    stim_stream_player #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PASS_W(PASS_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .count    (count),
        .mode_loop(mode_loop),
        .start    (start),
        .stop     (stop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .word_idx (word_idx),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] mem_model [DEPTH];
    int n_checks = 0;
    int n_errors = 0;
    int beats = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int stall_cnt = 0;
    logic              stall_seen = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] hold_idx;
    logic              hold_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: transfers pop the expected queue; stalls must hold the presented word.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst_n && !stop && stall_seen) begin
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_data", out_data, hold_data);
            check("stall_hold_idx", word_idx, hold_idx);
            check("stall_hold_last", out_last, hold_last);
        end
        if (rst_n && !stop && out_valid && out_ready) begin
            beats++;
            if (beats == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e[DATA_W-1:0]);
                check("beat_idx", word_idx, e[DATA_W+ADDR_W-1:DATA_W]);
                check("beat_last", out_last, e[EXP_W-1]);
            end
        end
        stall_seen = rst_n && !stop && out_valid && !out_ready;
        if (stall_seen) stall_cnt++;
        hold_data = out_data;
        hold_idx  = word_idx;
        hold_last = out_last;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [DATA_W-1:0] data, input bit takes_effect);
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = data;
        tick();
        load_en = 1'b0;
        if (takes_effect) mem_model[addr] = data;
    endtask

    task automatic start_play(input int cnt, input logic loop);
        count     = (ADDR_W+1)'(cnt);
        mode_loop = loop;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_pass(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), ADDR_W'(i), mem_model[i]});
        end
    endtask

    task automatic clear_stats();
        beats     = 0;
        stall_cnt = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_reached"}, done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        count = '0; mode_loop = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_idx", word_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass_cnt, 0);
        rst_n = 1'b1;
        tick();

        // 1: one-shot at full rate
        load_word(0, 32'h11, 1);
        load_word(1, 32'h22, 1);
        load_word(2, 32'h33, 1);
        load_word(3, 32'h44, 1);
        clear_stats();
        out_ready = 1'b1;
        push_pass(4);
        start_play(4, 1'b0);
        wait_done(20, "t1");
        check("t1_beats", beats, 4);
        check("t1_full_rate", last_cyc - first_cyc, 3);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_pass", pass_cnt, 1);
        check("t1_valid_low", out_valid, 0);

        // 2: backpressure, ready pattern 1,0,0,1 repeating
        clear_stats();
        push_pass(4);
        start_play(4, 1'b0);
        for (int k = 0; k < 60 && !done; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        check("t2_done", done, 1);
        check("t2_beats", beats, 4);
        check("t2_stalls_seen", stall_cnt > 0, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: loop mode, three passes without bubbles
        clear_stats();
        out_ready = 1'b1;
        push_pass(3); push_pass(3); push_pass(3);
        start_play(3, 1'b1);
        for (int k = 0; k < 40 && beats < 9; k++) tick();
        out_ready = 1'b0;
        check("t3_beats", beats, 9);
        check("t3_no_bubble", last_cyc - first_cyc, 8);
        check("t3_pass", pass_cnt, 3);
        check("t3_done_low", done, 0);
        check("t3_busy", busy, 1);
        check("t3_queue_empty", exp_q.size(), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_valid", out_valid, 0);
        check("t3_stop_busy", busy, 0);
        check("t3_stop_pass_hold", pass_cnt, 3);

        // 4: stop while word 2 is presented with ready high
        clear_stats();
        out_ready = 1'b1;
        push_pass(2);
        exp_q[1][EXP_W-1] = 1'b0;
        start_play(4, 1'b0);
        for (int k = 0; k < 20 && word_idx != 2; k++) tick();
        check("t4_at_idx2", word_idx, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_valid", out_valid, 0);
        check("t4_idx", word_idx, 0);
        check("t4_last", out_last, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        repeat (3) tick();
        check("t4_beats", beats, 2);
        check("t4_queue_empty", exp_q.size(), 0);
        clear_stats();
        push_pass(4);
        start_play(4, 1'b0);
        wait_done(20, "t4_replay");
        check("t4_replay_beats", beats, 4);

        // 5: boundary counts
        clear_stats();
        start_play(0, 1'b0);
        repeat (3) tick();
        check("t5_cnt0_done", done, 1);
        check("t5_cnt0_busy", busy, 0);
        check("t5_cnt0_valid", out_valid, 0);
        check("t5_cnt0_beats", beats, 0);
        push_pass(1);
        start_play(1, 1'b0);
        wait_done(10, "t5_cnt1");
        check("t5_cnt1_beats", beats, 1);
        check("t5_cnt1_pass", pass_cnt, 1);
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom_range(32'h7fff_ffff, 0), 1);
        clear_stats();
        push_pass(DEPTH);
        start_play(DEPTH + 5, 1'b0);
        wait_done(60, "t5_big");
        check("t5_big_beats", beats, DEPTH);
        check("t5_big_queue_empty", exp_q.size(), 0);

        // 6: loads during RUN are ignored; loads in DONE land
        clear_stats();
        out_ready = 1'b0;
        start_play(4, 1'b0);
        check("t6_busy", busy, 1);
        load_word(0, 32'hdead_0000, 0);
        load_word(3, 32'hbeef_0003, 0);
        push_pass(4);
        out_ready = 1'b1;
        wait_done(20, "t6_run");
        push_pass(4);
        start_play(4, 1'b0);
        wait_done(20, "t6_next_pass");
        check("t6_beats", beats, 8);
        load_word(0, 32'h55, 1);
        push_pass(1);
        start_play(1, 1'b0);
        wait_done(10, "t6_done_load");
        check("t6_queue_empty", exp_q.size(), 0);

        // 6b: asynchronous reset mid-RUN
        out_ready = 1'b0;
        start_play(4, 1'b1);
        check("t6_rst_pre_valid", out_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_idx", word_idx, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pass", pass_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_after_rst_valid", out_valid, 0);
        check("t6_after_rst_done", done, 0);
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
